crc_word_unpacker: RTL

CRC_WORD_UNPACKER -- requirements
Module: crc_word_unpacker

---
 rtl/crc_word_unpacker.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/crc_word_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : crc_word_unpacker
//  Purpose  : Buffers 8/16/32-bit register writes in a small word FIFO and
//             serialises them into a byte stream for a downstream CRC engine.
//             The byte order within a word is set by MSB_FIRST.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             wr_en/wr_size/wr_data/wr_ready - register-side write port
//             flush               - drop all buffered and in-flight data
//             byte_out/byte_valid/byte_ready - byte stream handshake
//             level, busy         - buffer occupancy / activity status
//             overflow, ovf_clr   - sticky dropped-write flag and its clear
//             bytes_total         - wrapping count of bytes handed downstream
//  Revision : 1.0  initial release
// ============================================================================
module crc_word_unpacker #(
    parameter int DEPTH     = 4,     // 2, 4 or 8 word entries
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_size,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    input  logic        flush,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [3:0]  level,
    output logic        busy,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic [15:0] bytes_total
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [3:0] C_DEPTH = 4'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     shift_q, shift_d;
    logic [2:0]      rem_q, rem_d;
    logic [3:0]      level_q, level_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     total_q, total_d;

    // Word storage; byte count kept alongside as 1, 2 or 4
    logic [31:0]     mem_data_q [DEPTH];
    logic [2:0]      mem_cnt_q  [DEPTH];

    logic            w_wr_req;
    logic            w_push;
    logic            w_drop;
    logic            w_xfer;
    logic            w_last;
    logic            w_pop;
    logic [2:0]      w_wr_cnt;
    logic [31:0]     w_wr_data;
    logic [31:0]     w_head_data;
    logic [2:0]      w_head_cnt;
    logic [31:0]     w_load_word;
    logic [31:0]     w_shift_next;

    // Write classification; admission uses registered level only
    assign w_wr_req = wr_en && (wr_size != 2'b11) && !flush;
    assign w_push   = w_wr_req && (level_q < C_DEPTH);
    assign w_drop   = w_wr_req && (level_q == C_DEPTH);

    assign w_xfer   = (state_q == ST_SHIFT) && byte_ready;
    assign w_last   = w_xfer && (rem_q == 3'd1);
    assign w_pop    = !flush && (level_q != 4'd0) &&
                      ((state_q == ST_IDLE) || w_last);

    // Unused upper bytes are zeroed so the shifter empties to zero
    always_comb begin
        w_wr_cnt  = 3'd4;
        w_wr_data = wr_data;
        case (wr_size)
            2'b00: begin
                w_wr_cnt  = 3'd1;
                w_wr_data = {24'h0, wr_data[7:0]};
            end
            2'b01: begin
                w_wr_cnt  = 3'd2;
                w_wr_data = {16'h0, wr_data[15:0]};
            end
            default: begin
                w_wr_cnt  = 3'd4;
                w_wr_data = wr_data;
            end
        endcase
    end

    assign w_head_data = mem_data_q[rd_ptr_q];
    assign w_head_cnt  = mem_cnt_q[rd_ptr_q];

    // MSB-first: left-justify the valid bytes so the top byte goes out first
    always_comb begin
        w_load_word = w_head_data;
        if (MSB_FIRST) begin
            case (w_head_cnt)
                3'd1:    w_load_word = w_head_data << 24;
                3'd2:    w_load_word = w_head_data << 16;
                default: w_load_word = w_head_data;
            endcase
        end
    end

    assign w_shift_next = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        rem_d    = rem_q;
        level_d  = level_q + {3'b000, w_push} - {3'b000, w_pop};
        wr_ptr_d = w_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        total_d  = w_xfer ? total_q + 16'd1 : total_q;
        ovf_d    = ovf_q;

        // Set wins over clear
        if (w_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_pop) begin
                    shift_d = w_load_word;
                    rem_d   = w_head_cnt;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    if (w_pop) begin
                        // Back-to-back word: reload at the same edge
                        shift_d = w_load_word;
                        rem_d   = w_head_cnt;
                    end else begin
                        shift_d = 32'h0;
                        rem_d   = 3'd0;
                        state_d = ST_IDLE;
                    end
                end else if (w_xfer) begin
                    shift_d = w_shift_next;
                    rem_d   = rem_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush overrides buffer and shifter updates; the byte counter is kept
        if (flush) begin
            state_d  = ST_IDLE;
            shift_d  = 32'h0;
            rem_d    = 3'd0;
            level_d  = 4'd0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= 32'h0;
            rem_q    <= 3'd0;
            level_q  <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            total_q  <= 16'h0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            rem_q    <= rem_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            total_q  <= total_d;
        end
    end

    // Storage array needs no reset; occupancy is tracked by level/pointers
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_data_q[wr_ptr_q] <= w_wr_data;
            mem_cnt_q[wr_ptr_q]  <= w_wr_cnt;
        end
    end

    assign wr_ready    = (level_q < C_DEPTH);
    assign byte_valid  = (state_q == ST_SHIFT);
    assign byte_out    = MSB_FIRST ? shift_q[31:24] : shift_q[7:0];
    assign level       = level_q;
    assign busy        = (state_q == ST_SHIFT) || (level_q != 4'd0);
    assign overflow    = ovf_q;
    assign bytes_total = total_q;

endmodule
`default_nettype wire
